// File: rtl/host_rd_data_router_pkg.sv
// Shared types for the host read data router: ordering entry layout and FSM states.
package host_rd_data_router_pkg;

   localparam int unsigned N_REGIONS      = 4;
   localparam int unsigned AXI_DATA_BITS  = 512;
   localparam int unsigned ORD_LEN_BITS   = 28;
   localparam int unsigned ORD_VFID_BITS  = $clog2(N_REGIONS);

   // One ordering entry as issued by the host DMA arbiter.
   typedef struct packed {
      logic [ORD_VFID_BITS-1:0] vfid;
      logic [ORD_LEN_BITS-1:0]  len;
   } mux_host_t;

   typedef enum logic {
      ST_IDLE,
      ST_XFER
   } rd_state_e;

endpackage

// File: rtl/host_rd_ord_fifo.sv
// Generic synchronous FIFO with full/empty flags and asynchronous active-high clear.
module host_rd_ord_fifo #(
   parameter int unsigned WIDTH = 30,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   // Pointers carry one wrap bit to tell full from empty.
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en && !full) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_en && !empty) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !full) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/host_rd_data_router.sv
// Steers the shared XDMA host read data stream to per-region user streams in arbiter order.
module host_rd_data_router #(
   parameter int unsigned N_REGIONS = host_rd_data_router_pkg::N_REGIONS,
   parameter int unsigned DATA_BITS = host_rd_data_router_pkg::AXI_DATA_BITS,
   parameter int unsigned LEN_BITS  = host_rd_data_router_pkg::ORD_LEN_BITS,
   parameter int unsigned ORD_DEPTH = 16
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic                         s_mux_valid,
   output logic                         s_mux_ready,
   input  logic [$clog2(N_REGIONS)-1:0] s_mux_vfid,
   input  logic [LEN_BITS-1:0]          s_mux_len,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic [DATA_BITS-1:0]         s_axis_tdata,
   input  logic [DATA_BITS/8-1:0]       s_axis_tkeep,
   input  logic                         s_axis_tlast,
   output logic [N_REGIONS-1:0]         m_axis_tvalid,
   input  logic [N_REGIONS-1:0]         m_axis_tready,
   output logic [DATA_BITS-1:0]         m_axis_tdata,
   output logic [DATA_BITS/8-1:0]       m_axis_tkeep,
   output logic [N_REGIONS-1:0]         m_axis_tlast,
   output logic                         err_len0,
   output logic                         err_last
);

   import host_rd_data_router_pkg::*;

   localparam int unsigned VFID_W = $clog2(N_REGIONS);
   localparam int unsigned KEEP_W = DATA_BITS / 8;
   localparam int unsigned SHIFT  = $clog2(KEEP_W);
   localparam int unsigned SUM_W  = LEN_BITS + 1;
   localparam int unsigned CNT_W  = LEN_BITS - SHIFT + 1;

   rd_state_e         state_q, state_d;
   logic [VFID_W-1:0] sel_q, sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_len0_q, err_len0_d;
   logic              err_last_q, err_last_d;
   logic              up_q, up_d;

   mux_host_t         ord_wr, ord_head;
   logic              ord_push, ord_pop, ord_full, ord_empty;
   logic              head_len0;
   logic [SUM_W-1:0]  head_beats;
   logic              xfer_hs;

   assign ord_wr      = '{vfid: s_mux_vfid, len: s_mux_len};
   // up_q keeps the ordering port closed while reset is held.
   assign s_mux_ready = up_q && !ord_full;
   assign ord_push    = s_mux_valid && s_mux_ready;

   host_rd_ord_fifo #(
      .WIDTH ($bits(mux_host_t)),
      .DEPTH (ORD_DEPTH)
   ) u_ord_fifo (
      .clk     (aclk),
      .rst     (areset),
      .wr_en   (ord_push),
      .wr_data (ord_wr),
      .rd_en   (ord_pop),
      .rd_data (ord_head),
      .full    (ord_full),
      .empty   (ord_empty)
   );

   // Widened sum so the maximum length cannot wrap before the shift.
   assign head_len0  = (ord_head.len == '0);
   assign head_beats = (SUM_W'(ord_head.len) + SUM_W'(KEEP_W - 1)) >> SHIFT;

   assign m_axis_tdata = s_axis_tdata;
   assign m_axis_tkeep = s_axis_tkeep;
   assign err_len0     = err_len0_q;
   assign err_last     = err_last_q;

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      cnt_d         = cnt_q;
      err_len0_d    = err_len0_q;
      err_last_d    = err_last_q;
      up_d          = 1'b1;
      ord_pop       = 1'b0;
      xfer_hs       = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tvalid = '0;
      m_axis_tlast  = '0;

      case (state_q)
         ST_IDLE: begin
            if (!ord_empty) begin
               ord_pop = 1'b1;
               if (head_len0) begin
                  err_len0_d = 1'b1;
               end else begin
                  sel_d   = ord_head.vfid;
                  cnt_d   = CNT_W'(head_beats - SUM_W'(1));
                  state_d = ST_XFER;
               end
            end
         end
         ST_XFER: begin
            m_axis_tvalid[sel_q] = s_axis_tvalid;
            m_axis_tlast[sel_q]  = (cnt_q == '0);
            s_axis_tready        = m_axis_tready[sel_q];
            xfer_hs              = s_axis_tvalid && m_axis_tready[sel_q];
            if (xfer_hs) begin
               if (s_axis_tlast && (cnt_q != '0)) begin
                  err_last_d = 1'b1;
               end
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (!ord_empty && !head_len0) begin
                  // Chain straight into the next transfer without an idle cycle.
                  ord_pop = 1'b1;
                  sel_d   = ord_head.vfid;
                  cnt_d   = CNT_W'(head_beats - SUM_W'(1));
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         cnt_q      <= '0;
         err_len0_q <= 1'b0;
         err_last_q <= 1'b0;
         up_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         err_len0_q <= err_len0_d;
         err_last_q <= err_last_d;
         up_q       <= up_d;
      end
   end

endmodule

// File: tb/tb_host_rd_data_router.sv
// Directed bench for host_rd_data_router: routing order, backpressure, FIFO full, errors, reset.
module tb_host_rd_data_router;

   localparam int unsigned NR = 4;
   localparam int unsigned DB = 512;
   localparam int unsigned LB = 28;
   localparam int unsigned KB = DB / 8;

   logic          aclk          = 1'b0;
   logic          areset        = 1'b1;
   logic          s_mux_valid   = 1'b0;
   logic          s_mux_ready;
   logic [1:0]    s_mux_vfid    = '0;
   logic [LB-1:0] s_mux_len     = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [DB-1:0] s_axis_tdata  = '0;
   logic [KB-1:0] s_axis_tkeep  = '1;
   logic          s_axis_tlast  = 1'b0;
   logic [NR-1:0] m_axis_tvalid;
   logic [NR-1:0] m_axis_tready = '1;
   logic [DB-1:0] m_axis_tdata;
   logic [KB-1:0] m_axis_tkeep;
   logic [NR-1:0] m_axis_tlast;
   logic          err_len0;
   logic          err_last;

   typedef struct {
      int          region;
      logic [63:0] data;
      logic        last;
      int          at;
   } beat_t;

   beat_t mon_q[$];
   int    cyc         = 0;
   bit    multi_valid = 1'b0;
   int    checks      = 0;
   int    failures    = 0;

   host_rd_data_router #(
      .N_REGIONS (NR),
      .DATA_BITS (DB),
      .LEN_BITS  (LB),
      .ORD_DEPTH (16)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_mux_valid   (s_mux_valid),
      .s_mux_ready   (s_mux_ready),
      .s_mux_vfid    (s_mux_vfid),
      .s_mux_len     (s_mux_len),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .err_len0      (err_len0),
      .err_last      (err_last)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) cyc <= cyc + 1;

   // Inputs only change just after posedge, so the negedge view is what the next edge accepts.
   always @(negedge aclk) begin
      if ($countones(m_axis_tvalid) > 1) multi_valid = 1'b1;
      for (int r = 0; r < NR; r++) begin
         if (m_axis_tvalid[r] && m_axis_tready[r]) begin
            mon_q.push_back('{region: r, data: m_axis_tdata[63:0], last: m_axis_tlast[r], at: cyc});
         end
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic push_ord(input logic [1:0] vfid, input logic [LB-1:0] len);
      bit ok;
      ok          = 1'b0;
      s_mux_valid = 1'b1;
      s_mux_vfid  = vfid;
      s_mux_len   = len;
      for (int w = 0; w < 50 && !ok; w++) begin
         #1;
         if (s_mux_ready) ok = 1'b1;
         tick();
      end
      s_mux_valid = 1'b0;
      if (!ok) check_val("push_timeout", 64'(ok), 64'(1));
   endtask

   task automatic send_beats(input logic [63:0] base, input int first, input int n, input logic [31:0] last_mask);
      for (int i = first; i < first + n; i++) begin
         bit ok;
         ok            = 1'b0;
         s_axis_tdata  = {8{base + 64'(i)}};
         s_axis_tlast  = last_mask[i];
         s_axis_tvalid = 1'b1;
         for (int w = 0; w < 50 && !ok; w++) begin
            #1;
            if (s_axis_tready) ok = 1'b1;
            tick();
         end
         if (!ok) check_val($sformatf("beat_timeout_%0d", i), 64'(ok), 64'(1));
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic exp_beat(input string tag, input int idx, input int region, input logic [63:0] data, input logic last);
      check_val($sformatf("%s_present%0d", tag, idx), 64'(idx < mon_q.size()), 64'(1));
      if (idx < mon_q.size()) begin
         check_val($sformatf("%s_region%0d", tag, idx), 64'(mon_q[idx].region), 64'(region));
         check_val($sformatf("%s_data%0d", tag, idx), mon_q[idx].data, data);
         check_val($sformatf("%s_last%0d", tag, idx), 64'(mon_q[idx].last), 64'(last));
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset state
      #2;
      check_val("rst_mux_ready", 64'(s_mux_ready), 64'(0));
      check_val("rst_s_tready", 64'(s_axis_tready), 64'(0));
      check_val("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
      check_val("rst_m_tlast", 64'(m_axis_tlast), 64'(0));
      check_val("rst_err_len0", 64'(err_len0), 64'(0));
      check_val("rst_err_last", 64'(err_last), 64'(0));
      repeat (3) @(posedge aclk);
      #1;
      areset = 1'b0;
      tick();
      check_val("post_rst_mux_ready", 64'(s_mux_ready), 64'(1));

      // Single transfer: vfid 2, 128 bytes = 2 beats
      mon_q.delete();
      multi_valid  = 1'b0;
      s_axis_tkeep = 64'h0123_4567_89AB_CDEF;
      push_ord(2'd2, 28'd128);
      tick();
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {8{64'h1100}};
      #1;
      check_val("t1_tvalid_onehot", 64'(m_axis_tvalid), 64'(4'b0100));
      check_val("t1_tkeep_pass", 64'(m_axis_tkeep), 64'h0123_4567_89AB_CDEF);
      check_val("t1_tlast_first", 64'(m_axis_tlast), 64'(0));
      send_beats(64'h1100, 0, 2, 32'b10);
      check_val("t1_count", 64'(mon_q.size()), 64'(2));
      exp_beat("t1", 0, 2, 64'h1100, 1'b0);
      exp_beat("t1", 1, 2, 64'h1101, 1'b1);
      check_val("t1_multi_valid", 64'(multi_valid), 64'(0));
      s_axis_tvalid = 1'b1;
      #1;
      check_val("t1_idle_s_tready", 64'(s_axis_tready), 64'(0));
      check_val("t1_idle_m_tvalid", 64'(m_axis_tvalid), 64'(0));
      s_axis_tvalid = 1'b0;
      s_axis_tkeep  = '1;
      tick();

      // Back-to-back: (0,64) -> 1 beat, (3,200) -> 4 beats, no bubble
      mon_q.delete();
      push_ord(2'd0, 28'd64);
      push_ord(2'd3, 28'd200);
      send_beats(64'h2200, 0, 5, 32'b10001);
      check_val("t2_count", 64'(mon_q.size()), 64'(5));
      exp_beat("t2", 0, 0, 64'h2200, 1'b1);
      exp_beat("t2", 1, 3, 64'h2201, 1'b0);
      exp_beat("t2", 2, 3, 64'h2202, 1'b0);
      exp_beat("t2", 3, 3, 64'h2203, 1'b0);
      exp_beat("t2", 4, 3, 64'h2204, 1'b1);
      if (mon_q.size() == 5) begin
         for (int i = 1; i < 5; i++) begin
            check_val($sformatf("t2_gap%0d", i), 64'(mon_q[i].at - mon_q[i-1].at), 64'(1));
         end
      end
      check_val("t2_err_last", 64'(err_last), 64'(0));

      // Backpressure: vfid 1, 256 bytes = 4 beats, region 1 stalls 5 cycles after beat 2
      mon_q.delete();
      push_ord(2'd1, 28'd256);
      send_beats(64'h3300, 0, 2, 32'b0);
      m_axis_tready = 4'b1101;
      s_axis_tdata  = {8{64'h3302}};
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check_val($sformatf("t3_bp_s_tready%0d", k), 64'(s_axis_tready), 64'(0));
         check_val($sformatf("t3_bp_m_tvalid%0d", k), 64'(m_axis_tvalid), 64'(4'b0010));
         tick();
      end
      m_axis_tready = '1;
      send_beats(64'h3300, 2, 2, 32'b1000);
      check_val("t3_count", 64'(mon_q.size()), 64'(4));
      exp_beat("t3", 0, 1, 64'h3300, 1'b0);
      exp_beat("t3", 1, 1, 64'h3301, 1'b0);
      exp_beat("t3", 2, 1, 64'h3302, 1'b0);
      exp_beat("t3", 3, 1, 64'h3303, 1'b1);

      // FIFO full: the first entry is popped straight into XFER, so 17 pushes fill 16 slots
      mon_q.delete();
      for (int i = 0; i < 16; i++) push_ord(2'd0, 28'd64);
      #1;
      check_val("t4_ready_before_17", 64'(s_mux_ready), 64'(1));
      push_ord(2'd0, 28'd64);
      #1;
      check_val("t4_full_ready", 64'(s_mux_ready), 64'(0));
      s_axis_tdata  = {8{64'h4400}};
      s_axis_tlast  = 1'b1;
      s_axis_tvalid = 1'b1;
      #1;
      check_val("t4_pop_s_tready", 64'(s_axis_tready), 64'(1));
      check_val("t4_pop_cycle_ready", 64'(s_mux_ready), 64'(0));
      tick();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      check_val("t4_release_ready", 64'(s_mux_ready), 64'(1));
      send_beats(64'h4400, 1, 16, 32'hFFFF_FFFF);
      check_val("t4_count", 64'(mon_q.size()), 64'(17));
      for (int i = 0; i < 17; i++) exp_beat("t4", i, 0, 64'h4400 + 64'(i), 1'b1);

      // Zero-length entry is flagged and skipped
      mon_q.delete();
      check_val("t5_err_len0_pre", 64'(err_len0), 64'(0));
      push_ord(2'd2, 28'd0);
      push_ord(2'd1, 28'd64);
      tick();
      check_val("t5_err_len0", 64'(err_len0), 64'(1));
      send_beats(64'h5500, 0, 1, 32'b1);
      check_val("t5_count", 64'(mon_q.size()), 64'(1));
      exp_beat("t5", 0, 1, 64'h5500, 1'b1);
      check_val("t5_err_last", 64'(err_last), 64'(0));

      // Early tlast on beat 1 of a 3-beat transfer (150 bytes)
      mon_q.delete();
      push_ord(2'd3, 28'd150);
      send_beats(64'h6600, 0, 3, 32'b101);
      check_val("t6_err_last", 64'(err_last), 64'(1));
      check_val("t6_count", 64'(mon_q.size()), 64'(3));
      exp_beat("t6", 0, 3, 64'h6600, 1'b0);
      exp_beat("t6", 1, 3, 64'h6601, 1'b0);
      exp_beat("t6", 2, 3, 64'h6602, 1'b1);

      // Asynchronous reset during beat 3 of a 4-beat transfer
      mon_q.delete();
      push_ord(2'd0, 28'd256);
      send_beats(64'h7700, 0, 2, 32'b0);
      s_axis_tdata  = {8{64'h7702}};
      s_axis_tvalid = 1'b1;
      #1;
      check_val("t7_mid_m_tvalid", 64'(m_axis_tvalid), 64'(4'b0001));
      areset = 1'b1;
      #1;
      check_val("t7_rst_mux_ready", 64'(s_mux_ready), 64'(0));
      check_val("t7_rst_s_tready", 64'(s_axis_tready), 64'(0));
      check_val("t7_rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
      check_val("t7_rst_m_tlast", 64'(m_axis_tlast), 64'(0));
      check_val("t7_rst_err_len0", 64'(err_len0), 64'(0));
      check_val("t7_rst_err_last", 64'(err_last), 64'(0));
      tick();
      areset        = 1'b0;
      s_axis_tvalid = 1'b0;
      mon_q.delete();
      tick();
      tick();
      push_ord(2'd1, 28'd64);
      send_beats(64'h7800, 0, 1, 32'b1);
      check_val("t7_count", 64'(mon_q.size()), 64'(1));
      exp_beat("t7", 0, 1, 64'h7800, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
